// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: accepts a word, pulses s, then shifts the word out on x one bit per clock.
// Define BIT_SERIALIZER_MSB_FIRST_EN to send the MSB first; the default build sends the LSB first.
module bit_serializer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           clear,
   input  logic [WIDTH-1:0]               din,
   input  logic                           din_valid,
   output logic                           din_ready,
   output logic                           s,
   output logic                           x,
   output logic                           x_valid,
   output logic                           busy,
   output logic                           done,
   output logic [$clog2(WIDTH+1)-1:0]     ones_cnt
);

   localparam int unsigned IW = $clog2(WIDTH);
   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_SHIFT,
      ST_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [IW-1:0]    bit_idx_q, bit_idx_d;
   logic [CW-1:0]    ones_cnt_q, ones_cnt_d;

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q    <= ST_IDLE;
         shreg_q    <= '0;
         bit_idx_q  <= '0;
         ones_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_idx_q  <= bit_idx_d;
         ones_cnt_q <= ones_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_idx_d  = bit_idx_q;
      ones_cnt_d = ones_cnt_q;
      din_ready  = 1'b0;
      s          = 1'b0;
      x          = 1'b0;
      x_valid    = 1'b0;
      done       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            din_ready = 1'b1;
            if (din_valid) begin
               shreg_d    = din;
               bit_idx_d  = '0;
               ones_cnt_d = '0;
               state_d    = ST_START;
            end
         end
         ST_START: begin
            s       = 1'b1;
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            x_valid = 1'b1;
`ifdef BIT_SERIALIZER_MSB_FIRST_EN
            x       = shreg_q[WIDTH-1];
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
`else
            x       = shreg_q[0];
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
`endif
            bit_idx_d  = bit_idx_q + IW'(1);
            ones_cnt_d = ones_cnt_q + CW'(x);
            if (bit_idx_q == LAST_IDX) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy     = (state_q != ST_IDLE);
   assign ones_cnt = ones_cnt_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer (WIDTH=8); follows BIT_SERIALIZER_MSB_FIRST_EN if defined.
module tb_bit_serializer;

   logic       clk;
   logic       clear;
   logic [7:0] din;
   logic       din_valid;
   logic       din_ready;
   logic       s;
   logic       x;
   logic       x_valid;
   logic       busy;
   logic       done;
   logic [3:0] ones_cnt;

   int n_cmp;
   int n_err;

   bit_serializer #(.WIDTH(8)) dut (
      .clk       (clk),
      .clear     (clear),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .s         (s),
      .x         (x),
      .x_valid   (x_valid),
      .busy      (busy),
      .done      (done),
      .ones_cnt  (ones_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Starts just after the accept edge; seq[i] is the i-th bit expected on x.
   task automatic observe_word(input string tag, input logic [7:0] seq, input logic [3:0] ones);
      @(negedge clk);
      din_valid = 1'b0;
      check({tag, "_s"}, 32'(s), 32'd1);
      check({tag, "_start_xv"}, 32'(x_valid), 32'd0);
      check({tag, "_start_busy"}, 32'(busy), 32'd1);
      check({tag, "_start_rdy"}, 32'(din_ready), 32'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("%s_xv%0d", tag, i), 32'(x_valid), 32'd1);
         check($sformatf("%s_x%0d", tag, i), 32'(x), 32'(seq[i]));
         check($sformatf("%s_s%0d", tag, i), 32'(s), 32'd0);
         check($sformatf("%s_dn%0d", tag, i), 32'(done), 32'd0);
      end
      @(negedge clk);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_done_xv"}, 32'(x_valid), 32'd0);
      check({tag, "_ones"}, 32'(ones_cnt), 32'(ones));
      @(negedge clk);
      check({tag, "_idle_rdy"}, 32'(din_ready), 32'd1);
      check({tag, "_idle_done"}, 32'(done), 32'd0);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_ones_hold"}, 32'(ones_cnt), 32'(ones));
   endtask

   task automatic run_word(input string tag, input logic [7:0] w, input logic [7:0] seq,
                           input logic [3:0] ones);
      din       = w;
      din_valid = 1'b1;
      check({tag, "_pre_rdy"}, 32'(din_ready), 32'd1);
      @(posedge clk);
      observe_word(tag, seq, ones);
   endtask

   logic [7:0] seq_b5, seq_01, seq_80;
   int acc_cyc[2];
   int nacc;

   initial begin
      n_cmp = 0;
      n_err = 0;
`ifdef BIT_SERIALIZER_MSB_FIRST_EN
      seq_b5 = 8'hAD;
      seq_01 = 8'h80;
      seq_80 = 8'h01;
`else
      seq_b5 = 8'hB5;
      seq_01 = 8'h01;
      seq_80 = 8'h80;
`endif

      // Reset with a word offered: clear must win, nothing is accepted.
      clear     = 1'b1;
      din       = 8'hFF;
      din_valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      clear     = 1'b0;
      din_valid = 1'b0;
      check("rst_rdy", 32'(din_ready), 32'd1);
      check("rst_s", 32'(s), 32'd0);
      check("rst_x", 32'(x), 32'd0);
      check("rst_xv", 32'(x_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ones", 32'(ones_cnt), 32'd0);

      @(negedge clk);
      run_word("b5", 8'hB5, seq_b5, 4'd5);
      run_word("ff", 8'hFF, 8'hFF, 4'd8);
      run_word("00", 8'h00, 8'h00, 4'd0);

      // Back-to-back with din_valid held; din changes while busy must be ignored.
      din       = 8'h01;
      din_valid = 1'b1;
      nacc      = 0;
      acc_cyc   = '{0, 0};
      for (int c = 0; c < 40 && nacc < 2; c++) begin
         if (c != 0) @(negedge clk);
         if (din_ready) begin
            acc_cyc[nacc] = c;
            nacc++;
         end else begin
            din = 8'h80;
         end
      end
      check("b2b_naccept", 32'(nacc), 32'd2);
      check("b2b_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd11);
      @(posedge clk);
      observe_word("b2b80", seq_80, 4'd1);

      // Mid-word clear on the 4th SHIFT cycle, then immediate new word.
      din       = 8'hB5;
      din_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      din_valid = 1'b0;
      check("mid_s", 32'(s), 32'd1);
      repeat (4) @(negedge clk);
      check("mid_xv4", 32'(x_valid), 32'd1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("mid_rdy", 32'(din_ready), 32'd1);
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_ones", 32'(ones_cnt), 32'd0);
      check("mid_done", 32'(done), 32'd0);
      check("mid_xv", 32'(x_valid), 32'd0);
      din       = 8'hFF;
      din_valid = 1'b1;
      @(posedge clk);
      observe_word("post_clr", 8'hFF, 4'd8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
